ascon_perm_iter: RTL and testbench
==================================

Name: ascon_perm_iter

Overview:
- Iterative Ascon permutation engine, one round per clock.
- Holds the 320-bit state register and the 4-bit round counter. Each cycle it applies constant addition, the 5-bit S-box layer and linear diffusion to the registered state.
- Runs p^a (12 rounds) or p^b (6 rounds) on request.
- Sits between the mode FSM (initialisation/AD/plaintext/finalisation) and the XOR/output logic.

Parameters:
- ROUNDS_A, 12, round count for mode_i=0. Legal range 1..12.
- ROUNDS_B, 6, round count for mode_i=1. Legal range 1..12.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a permutation; sampled only in IDLE.
- mode_i  in  1  0 = ROUNDS_A rounds, 1 = ROUNDS_B rounds; sampled with start_i.
- state_i  in  type_state (5x64)  state loaded on accepted start.
- state_o  out  type_state  registered state, continuously driven.
- round_o  out  4  round index applied at the next edge while busy.
- busy_o  out  1  high while rounds remain.
- done_o  out  1  one-cycle pulse: state_o holds the final permuted state.

Behaviour:
- Reset (async, active-high):
  - state register = 0, round counter = 0.
  - FSM = IDLE, busy_o = 0, done_o = 0.
  - Reset mid-permutation aborts the run; no done_o follows.
- FSM has two states: IDLE and RUN.
- IDLE, start_i = 1 at edge E0:
  - State register <= state_i.
  - Counter <= first round: 12 - R, where R = ROUNDS_A if mode_i = 0, else ROUNDS_B.
  - busy_o <= 1, go to RUN.
- IDLE, start_i = 0: register holds, busy_o = 0.
- RUN, each edge:
  - State register <= round(state register, counter).
  - If counter = 11: counter <= 0, busy_o <= 0, done_o <= 1, go to IDLE.
  - Otherwise counter increments.
- Latency: rounds are applied at edges E1..ER. done_o is high for exactly the cycle after ER. The result stays on state_o until the next accepted start.
- start_i while busy_o = 1 is ignored; the run completes unaffected.
- start_i high during the done_o cycle is accepted: back-to-back operation with no idle gap.
- round_o equals the counter. It is 0 in IDLE.
- Round function, on words x0..x4 (x0 = state[0]):
  - Constant addition:
    - x2 ^= {56'b0, C[counter]}.
    - C[0..11] = f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b (hex).
    - The same table as the existing constant-addition stage.
  - Substitution:
    - For each bit j in 0..63, the input is {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 as the MSB.
    - S-box table, indexed 0..31 (hex): 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
    - Output bits map back to x0..x4 in the same order.
  - Linear diffusion, ror = rotate right 64-bit:
    - x0 ^= ror(x0,19) ^ ror(x0,28)
    - x1 ^= ror(x1,61) ^ ror(x1,39)
    - x2 ^= ror(x2,1) ^ ror(x2,6)
    - x3 ^= ror(x3,10) ^ ror(x3,17)
    - x4 ^= ror(x4,7) ^ ror(x4,41)
  - The whole round is combinational between registers; no inner pipelining.
- Only the 64-bit low byte of x2 is affected by the constant; width exact, no truncation elsewhere.
- Counter never exceeds 11; values 12..15 are unreachable.

Test Plan:
- Reset check:
  - Assert reset_i mid-cycle -> immediately state_o = 0, busy_o = 0, done_o = 0, round_o = 0.
  - Release, idle 5 cycles -> outputs unchanged.
- p^a timing and value:
  - state_i = {80400c0600000000, 0, 0, 0, 0}, mode_i = 0, start 1 cycle.
  - round_o = 0,1,...,11 on successive cycles; busy_o high 12 cycles.
  - done_o high exactly one cycle, 13 edges after E0.
  - state_o equals the bench golden Ascon v1.2 p12 model.
- p^b timing and value:
  - Zero state, mode_i = 1.
  - round_o = 6..11; done_o at edge E0+7; busy_o high 6 cycles.
  - state_o matches golden p6 (first round uses constant 96).
- Start during busy:
  - Pulse start_i with a different state_i at round 3 -> ignored.
  - Result and done_o timing identical to the undisturbed run.
- Back-to-back:
  - start_i held high through done_o -> second run loads on the done_o cycle.
  - No idle gap; second done_o exactly R+1 edges later.
- Reset mid-run:
  - Assert reset_i at round 5, release, then start a fresh p^a.
  - No stray done_o; fresh result matches golden.

Source files
------------

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: one round per clock over a 320-bit state.
// The state is held as words x0..x4 with x0 at index 0.
module ascon_perm_iter #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [0:4][63:0]     state_i,
    output logic [0:4][63:0]     state_o,
    output logic [3:0]           round_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);

    logic [0:0]          fsm_q, fsm_d;
    logic [0:4][63:0]    state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic                done_q, done_d;

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hf - idx, idx};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [0:4][63:0] ascon_round(input logic [0:4][63:0] s,
                                                     input logic [3:0]       idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, round_const(idx)};
        x3 = s[3];
        x4 = s[4];
        // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    round_d = mode_i ? FIRST_B : FIRST_A;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d = ascon_round(state_q, round_q);
                if (round_q == 4'd11) begin
                    round_d = 4'd0;
                    done_d  = 1'b1;
                    fsm_d   = S_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = (fsm_q == S_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Directed bench for ascon_perm_iter: timing, golden p12/p6 values, start
// during busy, back-to-back starts and reset aborts.
module tb_ascon_perm_iter;

    typedef logic [0:4][63:0] st_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        mode_i;
    st_t         state_i;
    st_t         state_o;
    logic [3:0]  round_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ascon_perm_iter #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .state_i (state_i),
        .state_o (state_o),
        .round_o (round_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                  5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                  5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                  5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] ror_bits(input logic [63:0] x, input int n);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[(i + n) % 64];
        return r;
    endfunction

    // Reference permutation: per-column table lookup, bitwise rotations
    function automatic st_t model_perm(input st_t s_in, input int first);
        st_t s, t;
        logic [4:0] idx, o;
        s = s_in;
        for (int r = first; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ rc_tab[r];
            for (int j = 0; j < 64; j++) begin
                idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
                o = sbox_tab[idx];
                t[0][j] = o[4];
                t[1][j] = o[3];
                t[2][j] = o[2];
                t[3][j] = o[1];
                t[4][j] = o[0];
            end
            s[0] = t[0] ^ ror_bits(t[0], 19) ^ ror_bits(t[0], 28);
            s[1] = t[1] ^ ror_bits(t[1], 61) ^ ror_bits(t[1], 39);
            s[2] = t[2] ^ ror_bits(t[2], 1)  ^ ror_bits(t[2], 6);
            s[3] = t[3] ^ ror_bits(t[3], 10) ^ ror_bits(t[3], 17);
            s[4] = t[4] ^ ror_bits(t[4], 7)  ^ ror_bits(t[4], 41);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One permutation; optionally pulse a conflicting start when round_o hits disturb_round
    task automatic run_perm(input st_t s, input logic m, input int disturb_round, input string tag);
        int   nr;
        int   first;
        st_t  exp;
        nr    = m ? 6 : 12;
        first = 12 - nr;
        exp   = model_perm(s, first);
        state_i = s;
        mode_i  = m;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < nr; k++) begin
            chk($sformatf("%s_round%0d", tag, k), 320'(round_o), 320'(first + k));
            chk($sformatf("%s_busy%0d", tag, k), 320'(busy_o), 320'(1));
            chk($sformatf("%s_nodone%0d", tag, k), 320'(done_o), 320'(0));
            if (first + k == disturb_round) begin
                start_i = 1'b1;
                state_i = ~s;
                mode_i  = ~m;
            end
            tick();
            start_i = 1'b0;
        end
        chk({tag, "_done"}, 320'(done_o), 320'(1));
        chk({tag, "_idle"}, 320'(busy_o), 320'(0));
        chk({tag, "_round_idle"}, 320'(round_o), 320'(0));
        chk({tag, "_state"}, state_o, exp);
        tick();
        chk({tag, "_done_drop"}, 320'(done_o), 320'(0));
        chk({tag, "_state_hold"}, state_o, exp);
    endtask

    st_t iv_state;
    st_t st_b;
    st_t st_c;

    initial begin
        iv_state = {64'h80400c0600000000, 64'd0, 64'd0, 64'd0, 64'd0};
        st_b = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d};
        st_c = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                64'h4444444444444444, 64'h5555555555555555};
        reset_i = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        state_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();

        // Asynchronous reset while the register holds a nonzero state
        state_i = st_b;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #3 reset_i = 1'b1;
        #1;
        chk("reset_state", state_o, 320'(0));
        chk("reset_busy", 320'(busy_o), 320'(0));
        chk("reset_done", 320'(done_o), 320'(0));
        chk("reset_round", 320'(round_o), 320'(0));
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle_state%0d", i), state_o, 320'(0));
            chk($sformatf("idle_busy%0d", i), 320'(busy_o), 320'(0));
            chk($sformatf("idle_done%0d", i), 320'(done_o), 320'(0));
            chk($sformatf("idle_round%0d", i), 320'(round_o), 320'(0));
        end

        run_perm(iv_state, 1'b0, -1, "pa_iv");
        run_perm('0, 1'b1, -1, "pb_zero");
        run_perm(st_b, 1'b1, -1, "pb_b");
        run_perm(iv_state, 1'b0, 3, "pa_disturbed");

        // Back-to-back: start held high; second run loads on the done cycle
        state_i = st_b;
        mode_i  = 1'b1;
        start_i = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b1_round%0d", k), 320'(round_o), 320'(6 + k));
            tick();
        end
        chk("b2b1_done", 320'(done_o), 320'(1));
        chk("b2b1_state", state_o, model_perm(st_b, 6));
        state_i = st_c;
        mode_i  = 1'b0;
        tick();
        start_i = 1'b0;
        chk("b2b2_loaded_busy", 320'(busy_o), 320'(1));
        chk("b2b2_loaded_round", 320'(round_o), 320'(0));
        chk("b2b2_loaded_state", state_o, st_c);
        chk("b2b2_nodone", 320'(done_o), 320'(0));
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("b2b2_nodone%0d", k), 320'(done_o), 320'(0));
            tick();
        end
        chk("b2b2_done", 320'(done_o), 320'(1));
        chk("b2b2_state", state_o, model_perm(st_c, 0));
        tick();
        chk("b2b2_done_drop", 320'(done_o), 320'(0));

        // Reset mid-run: abort, no stray done, then a clean run
        state_i = st_c;
        mode_i  = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("abort_round5", 320'(round_o), 320'(5));
        reset_i = 1'b1;
        #1;
        chk("abort_busy", 320'(busy_o), 320'(0));
        chk("abort_round", 320'(round_o), 320'(0));
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), 320'(done_o), 320'(0));
            chk($sformatf("abort_idle%0d", i), 320'(busy_o), 320'(0));
        end
        run_perm(iv_state, 1'b0, -1, "pa_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
